// File: rtl/logic_op_pkg.sv
// logic_op_pkg
//   Operation encodings for the bitwise logic unit. The ALU control decoder
//   imports the same package, so both sides agree on the Op field.
//   OP_W       : width of the Op select field
//   logic_op_e : LOP_NOT .. LOP_PASS encodings (0..7)
package logic_op_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    LOP_NOT  = 3'd0,
    LOP_AND  = 3'd1,
    LOP_OR   = 3'd2,
    LOP_XOR  = 3'd3,
    LOP_NOR  = 3'd4,
    LOP_NAND = 3'd5,
    LOP_XNOR = 3'd6,
    LOP_PASS = 3'd7
  } logic_op_e;

endpackage

// File: rtl/logic_pipe_stage.sv
// logic_pipe_stage
//   One register stage of the valid/ready pipeline. The stage's ready term is
//   computed by the parent across the whole chain and arrives here as `load`.
//   Ports:
//     Clk       rising-edge clock
//     Rst       asynchronous active-low reset; clears valid and payload
//     load      this stage's ready: capture the upstream valid this cycle
//     up_valid  upstream valid
//     up_data   upstream payload (WIDTH bits)
//     dn_valid  registered valid
//     dn_data   registered payload
module logic_pipe_stage #(
  parameter int WIDTH = 33
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             load,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             dn_valid,
  output logic [WIDTH-1:0] dn_data
);

  logic             vld_p0;
  logic [WIDTH-1:0] data_p0;

  // Payload is captured only alongside a valid item, so junk on an idle
  // input never enters the register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else if (load) begin
      vld_p0 <= up_valid;
      if (up_valid) begin
        data_p0 <= up_data;
      end
    end
  end

  assign dn_valid = vld_p0;
  assign dn_data  = data_p0;

endmodule

// File: rtl/pipelined_logic_unit.sv
// pipelined_logic_unit
//   Bitwise logic unit (NOT/AND/OR/XOR/NOR/NAND/XNOR/PASS) followed by STAGES
//   valid/ready register stages. Result and Zero are formed combinationally
//   and travel together through the pipeline.
//   Ports:
//     Clk       rising-edge clock
//     Rst       asynchronous active-low reset
//     InValid   A/B/Op valid         InReady   unit accepts input this cycle
//     A, B      WIDTH-bit operands   Op        operation select (logic_op_e)
//     OutValid  Result/Zero valid    OutReady  downstream accepts
//     Result    WIDTH-bit result     Zero      Result == 0
module pipelined_logic_unit
  import logic_op_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [OP_W-1:0]  Op,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic             Zero
);

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("pipelined_logic_unit: STAGES must be in 1..4");
  end

  logic [WIDTH-1:0]          res_comb;
  logic                      zero_comb;
  logic [STAGES:0]           vld;
  logic [STAGES:0]           rdy;
  logic [STAGES:0][WIDTH:0]  data;

  always_comb begin
    res_comb = A;
    case (Op)
      LOP_NOT:  res_comb = ~A;
      LOP_AND:  res_comb = A & B;
      LOP_OR:   res_comb = A | B;
      LOP_XOR:  res_comb = A ^ B;
      LOP_NOR:  res_comb = ~(A | B);
      LOP_NAND: res_comb = ~(A & B);
      LOP_XNOR: res_comb = ~(A ^ B);
      LOP_PASS: res_comb = A;
      default:  res_comb = A;
    endcase
  end

  assign zero_comb = (res_comb == '0);
  assign vld[0]    = InValid;
  assign data[0]   = {zero_comb, res_comb};

  // A stage can load when it is empty or anything downstream moves, so one
  // bubble anywhere in the chain lets every stage behind it advance.
  always_comb begin
    rdy[STAGES] = OutReady;
    for (int i = STAGES - 1; i >= 0; i--) begin
      rdy[i] = ~vld[i+1] | rdy[i+1];
    end
  end

  // ---- stage boundaries: stage i registers vld/data[i] into vld/data[i+1]
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic_pipe_stage #(
      .WIDTH(WIDTH + 1)
    ) u_stage (
      .Clk     (Clk),
      .Rst     (Rst),
      .load    (rdy[i]),
      .up_valid(vld[i]),
      .up_data (data[i]),
      .dn_valid(vld[i+1]),
      .dn_data (data[i+1])
    );
  end

  assign InReady  = rdy[0];
  assign OutValid = vld[STAGES];
  assign Result   = data[STAGES][WIDTH-1:0];
  assign Zero     = data[STAGES][WIDTH];

endmodule
